// File: rtl/axi_ram_slave.sv
// AXI3 single-port RAM responder with independent read and write engines,
// one outstanding transaction each, FIXED/INCR bursts and a programmable read latency.
module axi_ram_slave #(
    parameter int MEM_AW   = 12,
    parameter int READ_LAT = 1,
    parameter int ID_W     = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);
    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] mem [DEPTH];

    // FIXED holds the address; INCR, WRAP and the reserved encoding all step by the beat size
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (burst == BURST_FIXED) begin
            return addr;
        end else begin
            return addr + (32'd1 << size);
        end
    endfunction

    logic [1:0]      rstate_q, rstate_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [31:0]     raddr_q, raddr_d;
    logic [3:0]      rlen_q, rlen_d;
    logic [2:0]      rsize_q, rsize_d;
    logic [1:0]      rburst_q, rburst_d;
    logic [3:0]      rbeat_q, rbeat_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rfetch_s;
    logic [31:0]     rfetch_addr_s;

    logic [1:0]      wstate_q, wstate_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [3:0]      wlen_q, wlen_d;
    logic [2:0]      wsize_q, wsize_d;
    logic [1:0]      wburst_q, wburst_d;
    logic [3:0]      wbeat_q, wbeat_d;
    logic            werr_q, werr_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            mem_we_s;
    logic            wbeat_end_s;
    logic            werr_s;

    logic unused_s;
    assign unused_s = ^{arlen[7:4], awlen[7:4], wid};

    // Read engine next-state: address latch, latency countdown, beat sequencing and data fetch
    always_comb begin
        rstate_d      = rstate_q;
        rid_d         = rid_q;
        raddr_d       = raddr_q;
        rlen_d        = rlen_q;
        rsize_d       = rsize_q;
        rburst_d      = rburst_q;
        rbeat_d       = rbeat_q;
        rcnt_d        = rcnt_q;
        rvalid_d      = rvalid_q;
        rlast_d       = rlast_q;
        rresp_d       = rresp_q;
        rfetch_s      = 1'b0;
        rfetch_addr_s = raddr_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rid_d    = arid;
                    raddr_d  = araddr;
                    rlen_d   = arlen[3:0];
                    rsize_d  = arsize;
                    rburst_d = arburst;
                    rbeat_d  = 4'd0;
                    rlast_d  = (arlen[3:0] == 4'd0);
                    rresp_d  = arburst[1] ? RESP_SLVERR : RESP_OKAY;
                    if (READ_LAT == 0) begin
                        rstate_d      = R_DATA;
                        rvalid_d      = 1'b1;
                        rfetch_s      = 1'b1;
                        rfetch_addr_s = araddr;
                    end else begin
                        rstate_d = R_WAIT;
                        rcnt_d   = 4'(READ_LAT);
                    end
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rcnt_q <= 4'd1) begin
                    rstate_d = R_DATA;
                    rvalid_d = 1'b1;
                    rfetch_s = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        rbeat_d       = rbeat_q + 4'd1;
                        raddr_d       = next_addr(raddr_q, rsize_q, rburst_q);
                        rfetch_s      = 1'b1;
                        rfetch_addr_s = raddr_d;
                        rlast_d       = ((rbeat_q + 4'd1) == rlen_q);
                    end
                end else begin
                    rstate_d = R_DATA;
                end
            end
            default: begin
                rstate_d = R_IDLE;
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        endcase
        arready_d = (rstate_d == R_IDLE);
        // A fetch in the same cycle as a write to the same word sees the old contents
        rdata_d   = rfetch_s ? mem[rfetch_addr_s[MEM_AW+1:2]] : rdata_q;
    end

    // Write engine next-state: burst tracking, protocol-error flag and response generation
    always_comb begin
        wstate_d    = wstate_q;
        bid_d       = bid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        mem_we_s    = 1'b0;
        wbeat_end_s = (wbeat_q == wlen_q);
        werr_s      = werr_q | (wlast != wbeat_end_s) | wburst_q[1];
        case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    bid_d    = awid;
                    waddr_d  = awaddr;
                    wlen_d   = awlen[3:0];
                    wsize_d  = awsize;
                    wburst_d = awburst;
                    wbeat_d  = 4'd0;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we_s = 1'b1;
                    werr_d   = werr_s;
                    waddr_d  = next_addr(waddr_q, wsize_q, wburst_q);
                    wbeat_d  = wbeat_q + 4'd1;
                    if (wlast || wbeat_end_s) begin
                        wstate_d = W_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = werr_s ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wstate_d = W_DATA;
                    end
                end else begin
                    wstate_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d = W_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    wstate_d = W_RESP;
                end
            end
            default: begin
                wstate_d = W_IDLE;
                bvalid_d = 1'b0;
            end
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
    end

    // Read engine registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= 32'd0;
            rlen_q    <= 4'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'b00;
            rbeat_q   <= 4'd0;
            rcnt_q    <= 4'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
        end else begin
            rstate_q  <= rstate_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write engine registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q  <= W_IDLE;
            bid_q     <= '0;
            waddr_q   <= 32'd0;
            wlen_q    <= 4'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'b00;
            wbeat_q   <= 4'd0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            wstate_q  <= wstate_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_s && wstrb[i]) begin
                mem[waddr_q[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: a word-array memory model predicts R beats and B
// responses at issue time; monitors on the R and B channels pop and compare.
module tb_axi_ram_slave;
    localparam int MEM_AW = 12;
    localparam int LAT    = 1;
    localparam int ID_W   = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [3:0] arid = 4'd0, awid = 4'd0, wid = 4'd0;
    logic [31:0] araddr = 32'd0, awaddr = 32'd0, wdata = 32'd0;
    logic [7:0] arlen = 8'd0, awlen = 8'd0;
    logic [2:0] arsize = 3'd0, awsize = 3'd0;
    logic [1:0] arburst = 2'b00, awburst = 2'b00;
    logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic [3:0] wstrb = 4'd0;
    logic rready = 1'b0, bready = 1'b0;
    logic arready, awready, wready, rvalid, rlast, bvalid;
    logic [3:0] rid, bid;
    logic [31:0] rdata;
    logic [1:0] rresp, bresp;

    axi_ram_slave #(.MEM_AW(MEM_AW), .READ_LAT(LAT), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rbeat_t rq[$];
    bexp_t  bq[$];
    logic [31:0] mdl [0:(1<<MEM_AW)-1];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int total = 0;
    int bad = 0;
    int rr_mode = 0;
    bit br_rand = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready drivers for the response channels
    always @(posedge aclk) begin
        #1;
        case (rr_mode)
            0: rready = 1'b1;
            1: rready = ~rready;
            default: rready = 1'($urandom_range(0, 1));
        endcase
        bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // R monitor: stability while stalled, then compare each accepted beat with the scoreboard
    rbeat_t r_e;
    bit held_v = 1'b0;
    logic [31:0] held_d;
    logic held_l;
    always @(negedge aclk) begin
        if (!aresetn) begin
            held_v = 1'b0;
        end else if (rvalid) begin
            if (held_v) begin
                check("r_stable_data", rdata, held_d);
                check("r_stable_last", rlast, held_l);
            end
            if (rready) begin
                held_v = 1'b0;
                if (rq.size() == 0) begin
                    check("r_unexpected_beat", 1, 0);
                end else begin
                    r_e = rq.pop_front();
                    check("r_data", rdata, r_e.data);
                    check("r_last", rlast, r_e.last);
                    check("r_resp", rresp, r_e.resp);
                    check("r_id", rid, r_e.id);
                end
            end else begin
                held_v = 1'b1;
                held_d = rdata;
                held_l = rlast;
            end
        end else begin
            if (held_v) check("r_valid_dropped", 0, 1);
            held_v = 1'b0;
        end
    end

    // B monitor
    bexp_t b_e;
    always @(negedge aclk) begin
        if (aresetn && bvalid && bready) begin
            if (bq.size() == 0) begin
                check("b_unexpected", 1, 0);
            end else begin
                b_e = bq.pop_front();
                check("b_resp", bresp, b_e.resp);
                check("b_id", bid, b_e.id);
            end
        end
    end

    task automatic wait_ready(input int which, input string nm);
        int k = 0;
        forever begin
            @(negedge aclk);
            if ((which == 0 && arready) || (which == 1 && awready) || (which == 2 && wready)) break;
            k++;
            if (k > 200) begin
                check({nm, "_timeout"}, 0, 1);
                break;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit chk_lat, input bit wait_done);
        logic [31:0] a;
        int n;
        a = addr;
        for (int j = 0; j <= int'(len); j++) begin
            rq.push_back('{data: mdl[a[MEM_AW+1:2]], last: (j == int'(len)),
                           resp: (burst[1] ? 2'b10 : 2'b00), id: id});
            if (burst != 2'b00) a = a + (32'd1 << size);
        end
        @(posedge aclk);
        #1;
        arid = id; araddr = addr; arlen = {4'd0, len}; arsize = size; arburst = burst;
        arvalid = 1'b1;
        wait_ready(0, "ar");
        arvalid = 1'b0;
        if (chk_lat) begin
            n = 0;
            forever begin
                @(negedge aclk);
                if (rvalid || n > 40) break;
                n++;
            end
            check("rd_latency", n, LAT);
        end
        if (wait_done) begin
            n = 0;
            while (rq.size() != 0 && n < 2000) begin
                @(negedge aclk);
                n++;
            end
            if (rq.size() != 0) begin
                check("r_burst_timeout", rq.size(), 0);
                rq.delete();
            end
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int wl_at);
        logic [31:0] a;
        bit err, at_end, is_last;
        int acc, n;
        a = addr; err = burst[1]; acc = 0;
        for (int j = 0; j < 16; j++) begin
            at_end  = (j == int'(len));
            is_last = (j == wl_at);
            for (int i = 0; i < 4; i++)
                if (ws[j][i]) mdl[a[MEM_AW+1:2]][8*i +: 8] = wd[j][8*i +: 8];
            if (is_last != at_end) err = 1'b1;
            if (burst != 2'b00) a = a + (32'd1 << size);
            if (is_last || at_end) begin
                acc = j + 1;
                break;
            end
        end
        bq.push_back('{resp: (err ? 2'b10 : 2'b00), id: id});
        @(posedge aclk);
        #1;
        awid = id; awaddr = addr; awlen = {4'd0, len}; awsize = size; awburst = burst;
        awvalid = 1'b1;
        wait_ready(1, "aw");
        awvalid = 1'b0;
        for (int j = 0; j < acc; j++) begin
            wvalid = 1'b1; wdata = wd[j]; wstrb = ws[j]; wlast = (j == wl_at);
            wait_ready(2, "w");
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 500) begin
            @(negedge aclk);
            n++;
        end
        if (bq.size() != 0) begin
            check("b_timeout", bq.size(), 0);
            bq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rid", rid, 0);
        check("rst_bid", bid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bresp", bresp, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("rel_arready", arready, 1);
        check("rel_awready", awready, 1);

        // Preload words 0..63 through the write channel
        for (int blk = 0; blk < 4; blk++) begin
            for (int j = 0; j < 16; j++) begin
                w = blk * 16 + j;
                if (w < 4) wd[j] = 32'hA0 + 32'(w);
                else if (w == 4) wd[j] = 32'h11223344;
                else if (w == 8) wd[j] = 32'hFFFFFFFF;
                else wd[j] = $urandom;
                ws[j] = 4'hF;
            end
            do_write(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, 15);
        end

        do_read(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, 1'b1, 1'b1);
        rr_mode = 1;
        do_read(4'd6, 32'h0, 4'd3, 3'd2, 2'b01, 1'b1, 1'b1);
        rr_mode = 0;

        wd[0] = 32'hDEADBEEF; ws[0] = 4'b0011;
        do_write(4'd7, 32'h20, 4'd0, 3'd2, 2'b01, 0);
        do_read(4'd7, 32'h20, 4'd0, 3'd2, 2'b01, 1'b1, 1'b1);

        for (int j = 0; j < 16; j++) begin wd[j] = 32'hC0DE0000 + 32'(j); ws[j] = 4'hF; end
        do_write(4'd8, 32'h40, 4'd3, 3'd2, 2'b01, 1);
        do_read(4'd8, 32'h40, 4'd3, 3'd2, 2'b01, 1'b1, 1'b1);

        do_read(4'd9, 32'h8, 4'd1, 3'd2, 2'b00, 1'b1, 1'b1);
        do_read(4'd10, 32'h0, 4'd2, 3'd2, 2'b10, 1'b1, 1'b1);
        do_write(4'd11, 32'h60, 4'd1, 3'd2, 2'b01, -1);
        do_read(4'd12, 32'h10 | (32'd1 << (MEM_AW + 2)), 4'd0, 3'd2, 2'b01, 1'b1, 1'b1);

        rr_mode = 2;
        br_rand = 1'b1;
        for (int t = 0; t < 24; t++) begin
            logic [31:0] ad;
            logic [3:0] ln;
            logic [2:0] sz;
            logic [1:0] bu;
            ad = 32'($urandom_range(0, 40)) << 2;
            ln = 4'($urandom_range(0, 15));
            sz = 3'($urandom_range(0, 2));
            bu = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 16; j++) begin
                    wd[j] = $urandom;
                    ws[j] = 4'($urandom_range(0, 15));
                end
                do_write(4'($urandom), ad, ln, sz, bu,
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'(ln));
            end else begin
                do_read(4'($urandom), ad, ln, sz, bu, 1'b1, 1'b1);
            end
        end
        rr_mode = 0;
        br_rand = 1'b0;

        // Reset in the middle of a 4-beat read
        do_read(4'd3, 32'h0, 4'd3, 3'd2, 2'b01, 1'b0, 1'b0);
        n = 0;
        while (rq.size() > 3 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_arready", arready, 0);
        rq.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("midrst_rel_arready", arready, 1);
        do_read(4'd4, 32'h10, 4'd1, 3'd2, 2'b01, 1'b1, 1'b1);

        repeat (4) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
